uart_rx: RTL

UART receive stage that samples the serial input `rxd_i` using the configuration held in the UART register block. It deframes start, data, parity and stop bits, and buffers each good word in a show-ahead FIFO. The FIFO head and fill level feed the register block's feedback inputs (`fdb_dat_i`, `fdb_num_dat_i`); a register read of the data address pops the FIFO.

---
 rtl/uart_rx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receive stage. Synchronizes rxd_i, deframes start/data/parity/stop
// bits using a per-frame latched configuration, and queues good words in a
// show-ahead FIFO whose head and fill level feed the register block.
module uart_rx #(
    parameter int NUMB_DIV_CLK_WD = 16,
    parameter int NUMB_BIT_MAX    = 8,
    parameter int SIZE_FIFO       = 8,
    parameter int SIZE_FIFO_WD    = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUMB_DIV_CLK_WD-1:0] cfg_num_div_clk_i,
    input  logic [3:0]                 cfg_num_bit_i,
    input  logic [1:0]                 cfg_enm_parity_i,
    input  logic [1:0]                 cfg_siz_stop_i,
    input  logic                       rxd_i,
    input  logic                       pop_i,
    output logic [NUMB_BIT_MAX-1:0]    fdb_dat_o,
    output logic [SIZE_FIFO_WD-1:0]    fdb_num_dat_o,
    output logic                       err_parity_o,
    output logic                       err_frame_o,
    output logic                       err_ovf_o
);

    localparam int PTR_WD = $clog2(SIZE_FIFO);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                     state, state_nxt;
    logic                       rxd_meta, rxd_s;
    logic [NUMB_DIV_CLK_WD-1:0] div_cfg, div_p, cnt;
    logic [3:0]                 nbit_cfg, n_bits, bit_idx;
    logic                       par_en, par_odd, two_stop;
    logic [NUMB_BIT_MAX-1:0]    shreg, word;
    logic                       par_acc, par_bad, stop_bad, stop_idx;
    logic                       tick, start_det, last_stop, frame_bad, push_good;

    logic [NUMB_BIT_MAX-1:0]    mem [SIZE_FIFO];
    logic [PTR_WD-1:0]          wr_ptr, rd_ptr;
    logic [SIZE_FIFO_WD-1:0]    count;
    logic                       full, empty, do_push, do_pop;

    // Effective configuration seen at the start edge: clamp divider and bit count.
    assign div_cfg  = (cfg_num_div_clk_i < NUMB_DIV_CLK_WD'(4)) ? NUMB_DIV_CLK_WD'(4)
                                                               : cfg_num_div_clk_i;
    assign nbit_cfg = (cfg_num_bit_i == 4'd0 || int'(cfg_num_bit_i) > NUMB_BIT_MAX)
                      ? 4'(NUMB_BIT_MAX) : cfg_num_bit_i;

    // Sample strike: the bit counter has reached the last cycle of the bit period.
    assign tick = (state != ST_IDLE) && (cnt == div_p - NUMB_DIV_CLK_WD'(1));

    // Shift register fills from the MSB, so right-align by the unused bit count.
    assign word      = shreg >> (4'(NUMB_BIT_MAX) - n_bits);
    assign frame_bad = stop_bad | ~rxd_s;
    assign push_good = last_stop & ~frame_bad & ~par_bad;

    // Two-flop synchronizer; both flops idle high like the line.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its sources, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd_i;
            rxd_s    <= rxd_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state and frame strobes.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        last_stop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_nxt = ST_START;
                    start_det = 1'b1;
                end
            end
            ST_START: begin
                if (tick) state_nxt = rxd_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (tick && bit_idx == n_bits - 4'd1)
                    state_nxt = par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (tick) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (tick && (!two_stop || stop_idx)) begin
                    state_nxt = ST_IDLE;
                    last_stop = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame datapath: config latch, bit timing, data shift, parity and stop tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_p    <= NUMB_DIV_CLK_WD'(4);
            n_bits   <= 4'(NUMB_BIT_MAX);
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            two_stop <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            stop_idx <= 1'b0;
        end else if (start_det) begin
            div_p    <= div_cfg;
            n_bits   <= nbit_cfg;
            par_en   <= (cfg_enm_parity_i == 2'd1) || (cfg_enm_parity_i == 2'd2);
            par_odd  <= (cfg_enm_parity_i == 2'd1);
            two_stop <= (cfg_siz_stop_i != 2'd0);
            cnt      <= div_cfg >> 1;
            bit_idx  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            stop_idx <= 1'b0;
        end else if (state != ST_IDLE) begin
            cnt <= tick ? '0 : cnt + NUMB_DIV_CLK_WD'(1);
            if (tick) begin
                case (state)
                    ST_DATA: begin
                        shreg   <= {rxd_s, shreg[NUMB_BIT_MAX-1:1]};
                        par_acc <= par_acc ^ rxd_s;
                        bit_idx <= bit_idx + 4'd1;
                    end
                    ST_PARITY: par_bad  <= par_acc ^ rxd_s ^ par_odd;
                    ST_STOP: begin
                        stop_bad <= stop_bad | ~rxd_s;
                        stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered one-cycle error pulses; frame error wins over parity error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_frame_o  <= 1'b0;
            err_parity_o <= 1'b0;
            err_ovf_o    <= 1'b0;
        end else begin
            err_frame_o  <= last_stop & frame_bad;
            err_parity_o <= last_stop & ~frame_bad & par_bad;
            err_ovf_o    <= push_good & full & ~pop_i;
        end
    end

    assign full    = (count == SIZE_FIFO_WD'(SIZE_FIFO));
    assign empty   = (count == '0);
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_good & (~full | do_pop);

    // FIFO storage.
    // NOTE: the storage array is deliberately not reset; the count and pointers
    // define which entries are valid, and the head output is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= word;
    end

    // FIFO pointers and fill count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_WD'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_WD'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + SIZE_FIFO_WD'(1);
                2'b01:   count <= count - SIZE_FIFO_WD'(1);
                default: count <= count;
            endcase
        end
    end

    assign fdb_dat_o     = empty ? '0 : mem[rd_ptr];
    assign fdb_num_dat_o = count;

endmodule
